// File: rtl/palette_fade_ctrl.sv
// Frame-synchronous brightness sequencer (fade-out, fade-in, white flash)
// feeding a combinational palette, with a fixed two-stage pixel pipeline.
module palette_fade_ctrl #(
  parameter int unsigned STEP_FRAMES  = 4,
  parameter int unsigned FLASH_FRAMES = 6
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_start_i,
  input  logic       fade_out_req_i,
  input  logic       fade_in_req_i,
  input  logic       flash_req_i,
  input  logic [3:0] pixel_index_i,
  input  logic       pixel_valid_i,
  output logic [3:0] pal_index_o,
  input  logic [3:0] pal_red_i,
  input  logic [3:0] pal_green_i,
  input  logic [3:0] pal_blue_i,
  output logic [3:0] red_o,
  output logic [3:0] green_o,
  output logic [3:0] blue_o,
  output logic       rgb_valid_o,
  output logic [3:0] level_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned CW         = 4;
  localparam int unsigned MAX_FRAMES = (STEP_FRAMES > FLASH_FRAMES) ? STEP_FRAMES : FLASH_FRAMES;
  localparam int unsigned FCNT_W     = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam logic [CW-1:0] LVL_MAX  = CW'(15);
  localparam logic [CW-1:0] LVL_MIN  = CW'(0);

  typedef enum logic [2:0] {
    ST_BRIGHT,
    ST_FADE_OUT,
    ST_DARK,
    ST_FADE_IN,
    ST_FLASH
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     level_q, level_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [CW-1:0]     pal_index_q;
  logic              vld_q;
  logic [CW-1:0]     red_q, green_q, blue_q;
  logic [CW-1:0]     red_d, green_d, blue_d;
  logic              rgb_valid_q;

  logic [FCNT_W-1:0] limit_m1;
  logic              tick;

  // A tick is the frame_start that completes one step (or the whole flash).
  assign limit_m1 = (state_q == ST_FLASH) ? FCNT_W'(FLASH_FRAMES - 1)
                                          : FCNT_W'(STEP_FRAMES - 1);
  assign tick     = frame_start_i && (fcnt_q == limit_m1);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    fcnt_d  = fcnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_BRIGHT: begin
        if (flash_req_i) begin
          state_d = ST_FLASH;
          fcnt_d  = '0;
        end else if (fade_out_req_i) begin
          state_d = ST_FADE_OUT;
          fcnt_d  = '0;
        end
      end
      ST_FADE_OUT: begin
        if (tick) begin
          fcnt_d  = '0;
          level_d = level_q - CW'(1);
          if (level_q == CW'(1)) begin
            state_d = ST_DARK;
            done_d  = 1'b1;
          end
        end else if (frame_start_i) begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end
      ST_DARK: begin
        if (fade_in_req_i) begin
          state_d = ST_FADE_IN;
          fcnt_d  = '0;
        end
      end
      ST_FADE_IN: begin
        if (tick) begin
          fcnt_d  = '0;
          level_d = level_q + CW'(1);
          if (level_q == CW'(14)) begin
            state_d = ST_BRIGHT;
            done_d  = 1'b1;
          end
        end else if (frame_start_i) begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end
      ST_FLASH: begin
        if (tick) begin
          fcnt_d  = '0;
          state_d = ST_BRIGHT;
          done_d  = 1'b1;
        end else if (frame_start_i) begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_BRIGHT;
        level_d = LVL_MAX;
        fcnt_d  = '0;
      end
    endcase
    busy_d = (state_d == ST_FADE_OUT) || (state_d == ST_FADE_IN) || (state_d == ST_FLASH);
  end

  function automatic logic [CW-1:0] scale(input logic [CW-1:0] c,
                                          input logic [CW-1:0] lvl,
                                          input logic          flash);
    logic [2*CW-1:0] prod;
    prod = (2*CW)'(c) * (2*CW)'(lvl);
    if (flash)               scale = LVL_MAX;
    else if (lvl == LVL_MAX) scale = c;
    else                     scale = prod[2*CW-1:CW];
  endfunction

  // Second pipeline stage scales with the level held at the output edge.
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (vld_q) begin
      red_d   = scale(pal_red_i,   level_q, state_q == ST_FLASH);
      green_d = scale(pal_green_i, level_q, state_q == ST_FLASH);
      blue_d  = scale(pal_blue_i,  level_q, state_q == ST_FLASH);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_BRIGHT;
      level_q     <= LVL_MAX;
      fcnt_q      <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      pal_index_q <= '0;
      vld_q       <= 1'b0;
      red_q       <= LVL_MIN;
      green_q     <= LVL_MIN;
      blue_q      <= LVL_MIN;
      rgb_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      fcnt_q      <= fcnt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      pal_index_q <= pixel_index_i;
      vld_q       <= pixel_valid_i;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      rgb_valid_q <= vld_q;
    end
  end

  assign pal_index_o = pal_index_q;
  assign red_o       = red_q;
  assign green_o     = green_q;
  assign blue_o      = blue_q;
  assign rgb_valid_o = rgb_valid_q;
  assign level_o     = level_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Directed bench for palette_fade_ctrl: expected pixels queued at issue time,
// a monitor pops and compares whenever rgb_valid_o is seen.
module tb_palette_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start, fade_out_req, fade_in_req, flash_req;
  logic [3:0] pixel_index;
  logic       pixel_valid;
  logic [3:0] pal_index;
  logic [3:0] pal_red, pal_green, pal_blue;
  logic [3:0] red, green, blue;
  logic       rgb_valid;
  logic [3:0] level;
  logic       busy, done;

  int errors = 0;
  int checks = 0;
  logic [11:0] sb_q[$];

  always #5 clk = ~clk;

  // Palette model: index 3 returns B,9,6.
  assign pal_red   = pal_index + 4'd8;
  assign pal_green = pal_index + 4'd6;
  assign pal_blue  = pal_index + 4'd3;

  palette_fade_ctrl #(.STEP_FRAMES(2), .FLASH_FRAMES(3)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .frame_start_i (frame_start),
    .fade_out_req_i(fade_out_req),
    .fade_in_req_i (fade_in_req),
    .flash_req_i   (flash_req),
    .pixel_index_i (pixel_index),
    .pixel_valid_i (pixel_valid),
    .pal_index_o   (pal_index),
    .pal_red_i     (pal_red),
    .pal_green_i   (pal_green),
    .pal_blue_i    (pal_blue),
    .red_o         (red),
    .green_o       (green),
    .blue_o        (blue),
    .rgb_valid_o   (rgb_valid),
    .level_o       (level),
    .busy_o        (busy),
    .done_o        (done)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented pixel must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && rgb_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rgb_valid", 1, 0);
      end else begin
        check("rgb", int'({red, green, blue}), int'(sb_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic send_pixel(input logic [3:0] idx, input logic [11:0] exp_rgb);
    pixel_index = idx;
    pixel_valid = 1'b1;
    sb_q.push_back(exp_rgb);
    @(negedge clk);
    pixel_valid = 1'b0;
    check("pal_index", int'(pal_index), int'(idx));
    idle(2);
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0; fade_out_req = 1'b0; fade_in_req = 1'b0; flash_req = 1'b0;
    pixel_index = 4'd0; pixel_valid = 1'b0;
    idle(3);
    check("rst_level", int'(level), 15);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rgb_valid", int'(rgb_valid), 0);
    check("rst_rgb", int'({red, green, blue}), 0);
    check("rst_pal_index", int'(pal_index), 0);
    rst_n = 1'b1;
    idle(2);
    send_pixel(4'd3, 12'hB96);

    // Fade out: one level step every second frame_start.
    fade_out_req = 1'b1;
    @(negedge clk);
    fade_out_req = 1'b0;
    check("fo_busy_start", int'(busy), 1);
    for (int k = 1; k <= 30; k++) begin
      frame();
      check($sformatf("fo_level_k%0d", k), int'(level), 15 - k / 2);
      check($sformatf("fo_done_k%0d", k), int'(done), (k == 30) ? 1 : 0);
      check($sformatf("fo_busy_k%0d", k), int'(busy), (k == 30) ? 0 : 1);
      if (k == 10) begin
        fade_in_req = 1'b1;
        flash_req   = 1'b1;
        @(negedge clk);
        fade_in_req = 1'b0;
        flash_req   = 1'b0;
        check("fo_ignore_req_level", int'(level), 10);
        check("fo_ignore_req_busy", int'(busy), 1);
      end
      if (k == 14) send_pixel(4'd3, 12'h543);
    end
    idle(1);
    check("dark_done_one_cycle", int'(done), 0);

    // DARK ignores flash and fade-out requests.
    flash_req = 1'b1;
    @(negedge clk);
    flash_req = 1'b0;
    fade_out_req = 1'b1;
    @(negedge clk);
    fade_out_req = 1'b0;
    idle(1);
    check("dark_level", int'(level), 0);
    check("dark_busy", int'(busy), 0);
    send_pixel(4'd3, 12'h000);

    // Fade in back to full brightness.
    fade_in_req = 1'b1;
    @(negedge clk);
    fade_in_req = 1'b0;
    check("fi_busy_start", int'(busy), 1);
    for (int k = 1; k <= 30; k++) begin
      frame();
      check($sformatf("fi_level_k%0d", k), int'(level), k / 2);
      check($sformatf("fi_done_k%0d", k), int'(done), (k == 30) ? 1 : 0);
    end
    check("fi_busy_end", int'(busy), 0);
    send_pixel(4'd3, 12'hB96);

    // Flash wins over a simultaneous fade-out request.
    flash_req = 1'b1;
    fade_out_req = 1'b1;
    @(negedge clk);
    flash_req = 1'b0;
    fade_out_req = 1'b0;
    check("fl_busy", int'(busy), 1);
    check("fl_level", int'(level), 15);
    send_pixel(4'd3, 12'hFFF);
    for (int k = 1; k <= 3; k++) begin
      frame();
      check($sformatf("fl_done_k%0d", k), int'(done), (k == 3) ? 1 : 0);
      check($sformatf("fl_busy_k%0d", k), int'(busy), (k == 3) ? 0 : 1);
    end
    for (int k = 0; k < 8; k++) frame();
    check("fl_no_fade_level", int'(level), 15);
    check("fl_no_fade_busy", int'(busy), 0);
    send_pixel(4'd3, 12'hB96);

    // Asynchronous reset in the middle of a fade at level 6.
    fade_out_req = 1'b1;
    @(negedge clk);
    fade_out_req = 1'b0;
    for (int k = 0; k < 18; k++) frame();
    check("mid_level", int'(level), 6);
    pixel_index = 4'd3;
    pixel_valid = 1'b1;
    sb_q.push_back(12'h432);
    @(negedge clk);
    sb_q.push_back(12'h432);
    @(negedge clk);
    pixel_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rgb_valid", int'(rgb_valid), 1);
    check("mid_rgb", int'({red, green, blue}), 12'h432);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_level", int'(level), 15);
    check("arst_busy", int'(busy), 0);
    check("arst_rgb_valid", int'(rgb_valid), 0);
    check("arst_rgb", int'({red, green, blue}), 0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("post_rst_busy", int'(busy), 0);
    send_pixel(4'd3, 12'hB96);
    idle(3);
    check("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
